// File: rtl/cprv_pkg.sv
// Shared constants and the write-back request type for the cprv64g core.
// Used by cprv_writeback and cprv_wb_scoreboard.
package cprv_pkg;

    localparam int CPRV_XLEN      = 64;
    localparam int CPRV_REGADDR_W = 5;

    // One register-file write: destination and value.
    typedef struct packed {
        logic [CPRV_REGADDR_W-1:0] rd;
        logic [CPRV_XLEN-1:0]      data;
    } wb_req_t;

endpackage

// File: rtl/cprv_wb_scoreboard.sv
// Pending-write scoreboard: one busy flag per architectural register,
// set on long-latency issue and cleared when that result is accepted.
module cprv_wb_scoreboard
    import cprv_pkg::*;
#(
    parameter int REGADDR_WIDTH = CPRV_REGADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          set_en,
    input  logic [REGADDR_WIDTH-1:0]      set_rd,
    input  logic                          clr_en,
    input  logic [REGADDR_WIDTH-1:0]      clr_rd,
    output logic [(1<<REGADDR_WIDTH)-1:0] busy
);

    logic [(1<<REGADDR_WIDTH)-1:0] busy_nxt;

    // Set is applied after clear so a same-cycle issue to the retiring register wins.
    always_comb begin
        busy_nxt = busy;
        if (clr_en) busy_nxt[clr_rd] = 1'b0;
        if (set_en) busy_nxt[set_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

endmodule

// File: rtl/cprv_writeback.sv
// cprv64g write-back stage: arbitrates ALU and long-latency results onto the
// single register-file write port. Optional operand forwarding: CPRV_WB_FWD_EN.
module cprv_writeback
    import cprv_pkg::*;
#(
    parameter int DATA_WIDTH    = CPRV_XLEN,
    parameter int REGADDR_WIDTH = CPRV_REGADDR_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REGADDR_WIDTH-1:0]      alu_rd,
    input  logic [DATA_WIDTH-1:0]         alu_data,
    input  logic                          lsu_valid,
    output logic                          lsu_ready,
    input  logic [REGADDR_WIDTH-1:0]      lsu_rd,
    input  logic [DATA_WIDTH-1:0]         lsu_data,
    input  logic                          iss_valid,
    input  logic [REGADDR_WIDTH-1:0]      iss_rd,
`ifdef CPRV_WB_FWD_EN
    input  logic [REGADDR_WIDTH-1:0]      rs1_addr,
    input  logic [REGADDR_WIDTH-1:0]      rs2_addr,
    input  logic [DATA_WIDTH-1:0]         rs1_rf,
    input  logic [DATA_WIDTH-1:0]         rs2_rf,
    output logic [DATA_WIDTH-1:0]         rs1_val,
    output logic [DATA_WIDTH-1:0]         rs2_val,
`endif
    output logic [(1<<REGADDR_WIDTH)-1:0] busy,
    output logic                          wb_en,
    output logic [REGADDR_WIDTH-1:0]      wb_addr,
    output logic [DATA_WIDTH-1:0]         wb_data
);

    wb_req_t alu_req, lsu_req, hold, sel;
    logic    hold_full, sel_vld, capture, src_ready;

    assign alu_req   = '{rd: alu_rd, data: alu_data};
    assign lsu_req   = '{rd: lsu_rd, data: lsu_data};
    assign src_ready = !hold_full && rst_n;
    assign alu_ready = src_ready;
    assign lsu_ready = src_ready;

    // A collision parks the ALU result; the lsu result goes out first.
    assign capture = !hold_full && lsu_valid && alu_valid;

    always_comb begin
        sel_vld = 1'b0;
        sel     = alu_req;
        if (hold_full) begin
            sel_vld = 1'b1;
            sel     = hold;
        end else if (lsu_valid) begin
            sel_vld = 1'b1;
            sel     = lsu_req;
        end else if (alu_valid) begin
            sel_vld = 1'b1;
            sel     = alu_req;
        end
    end

    // Write-port register stage; x0 results are consumed without a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full <= 1'b0;
            wb_en     <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
        end else begin
            hold_full <= capture;
            wb_en     <= sel_vld && (sel.rd != '0);
            if (sel_vld) begin
                wb_addr <= sel.rd;
                wb_data <= sel.data;
            end
        end
    end

    // Hold payload is only meaningful while hold_full is set.
    always_ff @(posedge clk) begin
        if (capture) hold <= alu_req;
    end

    cprv_wb_scoreboard #(
        .REGADDR_WIDTH (REGADDR_WIDTH)
    ) u_scoreboard (
        .clk    (clk),
        .rst_n  (rst_n),
        .set_en (iss_valid),
        .set_rd (iss_rd),
        .clr_en (lsu_valid && lsu_ready),
        .clr_rd (lsu_rd),
        .busy   (busy)
    );

`ifdef CPRV_WB_FWD_EN
    assign rs1_val = (wb_en && wb_addr == rs1_addr && rs1_addr != '0) ? wb_data : rs1_rf;
    assign rs2_val = (wb_en && wb_addr == rs2_addr && rs2_addr != '0) ? wb_data : rs2_rf;
`else
    // No bypass: decode stalls one extra cycle on a pending write-back.
`endif

endmodule

// File: tb/tb_cprv_writeback.sv
// Testbench for cprv_writeback: directed stimulus, expected writes queued and
// compared by a negedge monitor; also covers readies, busy and reset.
module tb_cprv_writeback;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    logic        clk, rst_n;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready, iss_valid;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, wb_addr;
    logic [63:0] alu_data, lsu_data, wb_data;
    logic [31:0] busy;
    logic        wb_en;
`ifdef CPRV_WB_FWD_EN
    logic [4:0]  rs1_addr, rs2_addr;
    logic [63:0] rs1_rf, rs2_rf, rs1_val, rs2_val;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    cprv_writeback dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
`ifdef CPRV_WB_FWD_EN
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_rf    (rs1_rf),
        .rs2_rf    (rs2_rf),
        .rs1_val   (rs1_val),
        .rs2_val   (rs2_val),
`endif
        .busy      (busy),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        exp_t e;
        e.rd   = rd;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wb_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got x%0d=0x%0h expected no write", wb_addr, wb_data);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wb_addr", {59'd0, wb_addr}, {59'd0, e.rd});
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
        iss_valid = 1'b0; iss_rd = '0;
`ifdef CPRV_WB_FWD_EN
        rs1_addr = '0; rs2_addr = '0; rs1_rf = '0; rs2_rf = '0;
`endif
        step(); step();
        chk("rst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("rst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("rst_wb_data", wb_data, 64'd0);
        chk("rst_busy", {32'd0, busy}, 64'd0);
        chk("rst_ready", {62'd0, alu_ready, lsu_ready}, 64'd0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", {62'd0, alu_ready, lsu_ready}, 64'd3);

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        push(5'd5, 64'h1234);
        step();
        alu_valid = 1'b0;
        chk("alu_only_wb_en", {63'd0, wb_en}, 64'd1);
        chk("alu_only_ready", {63'd0, alu_ready}, 64'd1);

        // Collision, with a new lsu result waiting through the hold cycle
        lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 64'hAA;
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 64'hBB;
        push(5'd3, 64'hAA); push(5'd4, 64'hBB); push(5'd6, 64'h66);
        step();
        alu_valid = 1'b0;
        lsu_rd = 5'd6; lsu_data = 64'h66;
        chk("coll_c1_addr", {59'd0, wb_addr}, 64'd3);
        chk("coll_c1_ready", {62'd0, alu_ready, lsu_ready}, 64'd0);
        step();
        chk("coll_c2_addr", {59'd0, wb_addr}, 64'd4);
        chk("coll_c2_wb_en", {63'd0, wb_en}, 64'd1);
        chk("coll_c2_ready", {62'd0, alu_ready, lsu_ready}, 64'd3);
        step();
        lsu_valid = 1'b0;
        chk("coll_c3_addr", {59'd0, wb_addr}, 64'd6);

        // x0 destination: consumed, no strobe, data still updates
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'hFF;
        step();
        alu_valid = 1'b0;
        chk("x0_wb_en", {63'd0, wb_en}, 64'd0);
        chk("x0_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("x0_wb_data", wb_data, 64'hFF);
        step();

        // Scoreboard
        iss_valid = 1'b1; iss_rd = 5'd7;
        step();
        iss_valid = 1'b0;
        chk("busy_set7", {32'd0, busy}, 64'h80);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h77;
        push(5'd7, 64'h77);
        step();
        lsu_valid = 1'b0;
        chk("busy_clr7", {32'd0, busy}, 64'h0);
        iss_valid = 1'b1; iss_rd = 5'd7;
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h78;
        push(5'd7, 64'h78);
        step();
        iss_valid = 1'b0; lsu_valid = 1'b0;
        chk("busy_set_wins", {32'd0, busy}, 64'h80);
        iss_valid = 1'b1; iss_rd = 5'd0;
        step();
        iss_valid = 1'b0;
        chk("busy_x0", {32'd0, busy}, 64'h80);
        iss_valid = 1'b1; iss_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        push(5'd9, 64'h99);
        step();
        iss_valid = 1'b0; alu_valid = 1'b0;
        chk("busy_alu_no_clr", {32'd0, busy}, 64'h280);
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 64'h79;
        push(5'd7, 64'h79);
        step();
        lsu_rd = 5'd9; lsu_data = 64'h90;
        push(5'd9, 64'h90);
        chk("busy_clr7b", {32'd0, busy}, 64'h200);
        step();
        lsu_valid = 1'b0;
        chk("busy_clr9", {32'd0, busy}, 64'h0);

        // Reset while the hold register is full; the x10 strobe is cut before the monitor samples
        iss_valid = 1'b1; iss_rd = 5'd12;
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 64'hA0;
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 64'hB0;
        step();
        iss_valid = 1'b0; lsu_valid = 1'b0; alu_valid = 1'b0;
        chk("mid_hold_ready", {63'd0, alu_ready}, 64'd0);
        chk("mid_busy12", {32'd0, busy}, 64'h1000);
        rst_n = 1'b0;
        #1;
        chk("arst_wb_en", {63'd0, wb_en}, 64'd0);
        chk("arst_wb_addr", {59'd0, wb_addr}, 64'd0);
        chk("arst_wb_data", wb_data, 64'd0);
        chk("arst_busy", {32'd0, busy}, 64'd0);
        chk("arst_ready", {62'd0, alu_ready, lsu_ready}, 64'd0);
        step(); step();
        rst_n = 1'b1;
        #1;
        chk("rerel_ready", {62'd0, alu_ready, lsu_ready}, 64'd3);
        step();
        chk("no_stale_write", {63'd0, wb_en}, 64'd0);
        step(); step();

`ifdef CPRV_WB_FWD_EN
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h55;
        push(5'd9, 64'h55);
        step();
        alu_valid = 1'b0;
        rs1_addr = 5'd9; rs1_rf = 64'h11;
        rs2_addr = 5'd8; rs2_rf = 64'h22;
        #1;
        chk("fwd_rs1", rs1_val, 64'h55);
        chk("fwd_rs2", rs2_val, 64'h22);
        step();
`endif

        step(); step();
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
